v_ew_seq: RTL and testbench

Element-wise vector operation sequencer. Sits directly around the banked vector register file: it drives one shared per-lane read address to two source register instances (A and B), combines the returned lane data with an ALU op, and drives per-lane write ports of a destination register instance. Each cycle, lane i handles element step*lanes_p+i, so lane i always writes its own bank. A start/ready handshake accepts one instruction; done_o flags completion.

---
 rtl/v_ew_seq.sv | 125 ++++++++++++
 tb/tb_v_ew_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/v_ew_seq.sv
`default_nettype none
// ============================================================================
// Module   : v_ew_seq
// Purpose  : Element-wise vector sequencer; lane i reads/writes element
//            step*lanes_p+i of banked A/B sources and a destination.
// Revision : 1.0 - initial release
// ============================================================================
module v_ew_seq #(
    parameter int vlen_p  = 8,
    parameter int vdw_p   = 32,
    parameter int lanes_p = 4,
    localparam int addr_width_lp = (vlen_p > 1) ? $clog2(vlen_p) : 1,
    localparam int steps_lp      = vlen_p / lanes_p
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic                                     start_i,
    output logic                                     ready_o,
    input  logic [1:0]                               op_i,
    input  logic [addr_width_lp:0]                   vl_i,
    output logic [lanes_p-1:0][addr_width_lp-1:0]    r_addr_o,
    input  logic [lanes_p-1:0][vdw_p-1:0]            a_data_i,
    input  logic [lanes_p-1:0][vdw_p-1:0]            b_data_i,
    output logic [lanes_p-1:0][addr_width_lp-1:0]    w_addr_o,
    output logic [lanes_p-1:0][vdw_p-1:0]            w_data_o,
    output logic [lanes_p-1:0]                       w_en_o,
    output logic                                     done_o
);

    localparam int ELEM_W = addr_width_lp + 1;
    localparam int STEP_W = (steps_lp > 1) ? $clog2(steps_lp) : 1;
    localparam logic [STEP_W-1:0] c_last_step = STEP_W'(steps_lp - 1);
    localparam logic [ELEM_W-1:0] c_vlen      = ELEM_W'(vlen_p);
    localparam logic [ELEM_W-1:0] c_lanes     = ELEM_W'(lanes_p);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                                  state_q;
    logic [STEP_W-1:0]                       step_q;
    logic [1:0]                              op_q;
    logic [ELEM_W-1:0]                       vl_q;
    logic [lanes_p-1:0][addr_width_lp-1:0]   w_addr_q;
    logic [lanes_p-1:0][vdw_p-1:0]           w_data_q;
    logic [lanes_p-1:0]                      w_en_q;
    logic                                    done_q;

    logic [lanes_p-1:0][ELEM_W-1:0]          w_elem;
    logic [lanes_p-1:0][vdw_p-1:0]           w_data_d;
    logic [ELEM_W-1:0]                       w_vl_clamped;

    // Element index is kept one bit wider so the vl compare covers vl == vlen_p.
    generate
        for (genvar i = 0; i < lanes_p; i++) begin : g_lane
            assign w_elem[i]   = ELEM_W'(step_q) * c_lanes + ELEM_W'(i);
            assign r_addr_o[i] = w_elem[i][addr_width_lp-1:0];

            always_comb begin
                w_data_d[i] = '0;
                case (op_q)
                    2'b00:   w_data_d[i] = a_data_i[i] + b_data_i[i];
                    2'b01:   w_data_d[i] = a_data_i[i] - b_data_i[i];
                    2'b10:   w_data_d[i] = a_data_i[i] & b_data_i[i];
                    default: w_data_d[i] = a_data_i[i] ^ b_data_i[i];
                endcase
            end
        end
    endgenerate

    assign w_vl_clamped = (vl_i > c_vlen) ? c_vlen : vl_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            step_q   <= '0;
            op_q     <= '0;
            vl_q     <= '0;
            w_addr_q <= '0;
            w_data_q <= '0;
            w_en_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            w_en_q <= '0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        op_q    <= op_i;
                        vl_q    <= w_vl_clamped;
                        step_q  <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < lanes_p; i++) begin
                        w_addr_q[i] <= r_addr_o[i];
                        w_data_q[i] <= w_data_d[i];
                        w_en_q[i]   <= (w_elem[i] < vl_q);
                    end
                    // done is registered here so it lines up with the final write.
                    if (step_q == c_last_step) begin
                        step_q  <= '0;
                        done_q  <= 1'b1;
                        state_q <= ST_DRAIN;
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                ST_DRAIN: state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign ready_o  = (state_q == ST_IDLE);
    assign w_addr_o = w_addr_q;
    assign w_data_o = w_data_q;
    assign w_en_o   = w_en_q;
    assign done_o   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_v_ew_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_v_ew_seq
// Purpose  : Directed self-checking bench for v_ew_seq (4-lane and 1-lane).
// Revision : 1.0 - initial release
// ============================================================================
module tb_v_ew_seq;

    logic clk;
    logic rst;

    // 4-lane, vlen 8 instance
    logic              start;
    logic              ready;
    logic [1:0]        op;
    logic [3:0]        vl;
    logic [3:0][2:0]   r_addr;
    logic [3:0][31:0]  a_data;
    logic [3:0][31:0]  b_data;
    logic [3:0][2:0]   w_addr;
    logic [3:0][31:0]  w_data;
    logic [3:0]        w_en;
    logic              done;

    // 1-lane, vlen 4 instance
    logic              start1;
    logic              ready1;
    logic [1:0]        op1;
    logic [2:0]        vl1;
    logic [0:0][1:0]   r_addr1;
    logic [0:0][31:0]  a_data1;
    logic [0:0][31:0]  b_data1;
    logic [0:0][1:0]   w_addr1;
    logic [0:0][31:0]  w_data1;
    logic [0:0]        w_en1;
    logic              done1;

    logic [31:0] amem [8];
    logic [31:0] bmem [8];
    logic [31:0] dmem [8];
    logic [31:0] a1mem [4];
    logic [31:0] b1mem [4];
    logic [31:0] dmem1 [4];
    logic        clr;
    logic [31:0] clr_val;

    int n_checks = 0;
    int n_fail   = 0;

    v_ew_seq #(.vlen_p(8), .vdw_p(32), .lanes_p(4)) u_dut (
        .clk_i(clk), .reset_i(rst), .start_i(start), .ready_o(ready),
        .op_i(op), .vl_i(vl), .r_addr_o(r_addr), .a_data_i(a_data),
        .b_data_i(b_data), .w_addr_o(w_addr), .w_data_o(w_data),
        .w_en_o(w_en), .done_o(done)
    );

    v_ew_seq #(.vlen_p(4), .vdw_p(32), .lanes_p(1)) u_dut1 (
        .clk_i(clk), .reset_i(rst), .start_i(start1), .ready_o(ready1),
        .op_i(op1), .vl_i(vl1), .r_addr_o(r_addr1), .a_data_i(a_data1),
        .b_data_i(b_data1), .w_addr_o(w_addr1), .w_data_o(w_data1),
        .w_en_o(w_en1), .done_o(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file models: combinational reads, clocked per-lane writes.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a_data[i] = amem[r_addr[i]];
            b_data[i] = bmem[r_addr[i]];
        end
        a_data1[0] = a1mem[r_addr1[0]];
        b_data1[0] = b1mem[r_addr1[0]];
    end

    always @(posedge clk) begin
        if (clr) begin
            for (int e = 0; e < 8; e++) dmem[e] <= clr_val;
            for (int e = 0; e < 4; e++) dmem1[e] <= clr_val;
        end else begin
            for (int i = 0; i < 4; i++)
                if (w_en[i]) dmem[w_addr[i]] <= w_data[i];
            if (w_en1[0]) dmem1[w_addr1[0]] <= w_data1[0];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preset(input logic [31:0] v);
        clr_val = v;
        clr     = 1'b1;
        tick();
        clr     = 1'b0;
    endtask

    task automatic load_src(input int mode);
        for (int e = 0; e < 8; e++) begin
            case (mode)
                0: begin amem[e] = 32'(e);         bmem[e] = 32'd100;        end
                1: begin amem[e] = 32'd0;          bmem[e] = 32'd1;          end
                2: begin amem[e] = 32'h1234_5678 + 32'(e * 7); bmem[e] = 32'h1234_5678 + 32'(e * 7); end
                default: begin amem[e] = 32'hF0F0_F0F0; bmem[e] = 32'h0FF0_0FF0; end
            endcase
        end
    endtask

    // Entered in cycle 0 with ready high; returns in the cycle after done.
    task automatic run_instr(input logic [1:0] o, input logic [3:0] v,
                             output int dc, output logic [3:0] en2, output logic [3:0] en3);
        dc = -1; en2 = '0; en3 = '0;
        start = 1'b1; op = o; vl = v;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            if (c == 2) en2 = w_en;
            if (c == 3) en3 = w_en;
            if (done && dc < 0) dc = c;
            if (dc >= 0 && c == dc + 1) break;
        end
    endtask

    int          dc;
    logic [3:0]  en2, en3;
    int          n_acc, n_done;
    logic        any_done;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; op = '0; vl = '0;
        start1 = 1'b0; op1 = '0; vl1 = '0; clr = 1'b0; clr_val = '0;
        for (int e = 0; e < 4; e++) begin a1mem[e] = 32'(e + 10); b1mem[e] = 32'(e); end
        load_src(0);
        tick(); tick();
        rst = 1'b0;

        check_eq("reset_ready", 64'(ready), 64'd1);
        check_eq("reset_wen", 64'(w_en), 64'd0);
        check_eq("reset_done", 64'(done), 64'd0);
        check_eq("reset_waddr", 64'(w_addr), 64'd0);
        check_eq("reset_wdata", 64'(w_data), 64'd0);

        // Add, vl=8, cycle-accurate
        preset(32'h0);
        start = 1'b1; op = 2'b00; vl = 4'd8;
        tick();
        start = 1'b0;
        check_eq("add_c1_ready", 64'(ready), 64'd0);
        check_eq("add_c1_wen", 64'(w_en), 64'd0);
        check_eq("add_c1_raddr3", 64'(r_addr[3]), 64'd3);
        tick();
        check_eq("add_c2_wen", 64'(w_en), 64'hF);
        check_eq("add_c2_wdata0", 64'(w_data[0]), 64'd100);
        check_eq("add_c2_wdata3", 64'(w_data[3]), 64'd103);
        check_eq("add_c2_waddr3", 64'(w_addr[3]), 64'd3);
        check_eq("add_c2_raddr3", 64'(r_addr[3]), 64'd7);
        check_eq("add_c2_done", 64'(done), 64'd0);
        tick();
        check_eq("add_c3_wen", 64'(w_en), 64'hF);
        check_eq("add_c3_wdata3", 64'(w_data[3]), 64'd107);
        check_eq("add_c3_waddr0", 64'(w_addr[0]), 64'd4);
        check_eq("add_c3_done", 64'(done), 64'd1);
        check_eq("add_c3_ready", 64'(ready), 64'd0);
        tick();
        check_eq("add_c4_ready", 64'(ready), 64'd1);
        check_eq("add_c4_done", 64'(done), 64'd0);
        check_eq("add_c4_wen", 64'(w_en), 64'd0);
        for (int e = 0; e < 8; e++) check_eq("add_mem", 64'(dmem[e]), 64'(100 + e));

        // Sub wrap followed back-to-back by xor with A == B
        load_src(1);
        preset(32'h5555_5555);
        run_instr(2'b01, 4'd8, dc, en2, en3);
        check_eq("sub_done_cycle", 64'(dc), 64'd3);
        for (int e = 0; e < 8; e++) check_eq("sub_mem", 64'(dmem[e]), 64'hFFFF_FFFF);
        load_src(2);
        run_instr(2'b11, 4'd8, dc, en2, en3);
        check_eq("xor_done_cycle", 64'(dc), 64'd3);
        for (int e = 0; e < 8; e++) check_eq("xor_mem", 64'(dmem[e]), 64'd0);

        // And
        load_src(3);
        run_instr(2'b10, 4'd8, dc, en2, en3);
        check_eq("and_mem0", 64'(dmem[0]), 64'h00F0_00F0);
        check_eq("and_mem7", 64'(dmem[7]), 64'h00F0_00F0);

        // vl = 5: partial second step
        load_src(0);
        preset(32'hDEAD_BEEF);
        run_instr(2'b00, 4'd5, dc, en2, en3);
        check_eq("vl5_en2", 64'(en2), 64'hF);
        check_eq("vl5_en3", 64'(en3), 64'h1);
        check_eq("vl5_done_cycle", 64'(dc), 64'd3);
        check_eq("vl5_mem4", 64'(dmem[4]), 64'd104);
        for (int e = 5; e < 8; e++) check_eq("vl5_untouched", 64'(dmem[e]), 64'hDEAD_BEEF);

        // vl = 0: no writes, done still pulses
        preset(32'hCAFE_0000);
        run_instr(2'b00, 4'd0, dc, en2, en3);
        check_eq("vl0_en2", 64'(en2), 64'h0);
        check_eq("vl0_en3", 64'(en3), 64'h0);
        check_eq("vl0_done_cycle", 64'(dc), 64'd3);
        check_eq("vl0_mem0", 64'(dmem[0]), 64'hCAFE_0000);

        // vl above vlen clamps to vlen
        preset(32'h0);
        run_instr(2'b00, 4'd12, dc, en2, en3);
        check_eq("vl12_en2", 64'(en2), 64'hF);
        check_eq("vl12_en3", 64'(en3), 64'hF);
        check_eq("vl12_mem7", 64'(dmem[7]), 64'd107);

        // start held high: one accept per 4-cycle window
        preset(32'h0);
        n_acc = 0; n_done = 0;
        start = 1'b1; op = 2'b00; vl = 4'd8;
        for (int k = 0; k < 12; k++) begin
            if (ready) n_acc++;
            if (done)  n_done++;
            tick();
        end
        start = 1'b0;
        check_eq("hold_accepts", 64'(n_acc), 64'd3);
        check_eq("hold_dones", 64'(n_done), 64'd3);
        check_eq("hold_ready_after", 64'(ready), 64'd1);
        check_eq("hold_mem6", 64'(dmem[6]), 64'd106);

        // Reset in the first RUN cycle
        preset(32'h7777_7777);
        start = 1'b1; op = 2'b00; vl = 4'd8;
        tick();
        start = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_mid_ready", 64'(ready), 64'd1);
        check_eq("rst_mid_wen", 64'(w_en), 64'd0);
        any_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            any_done = any_done | done;
            tick();
        end
        check_eq("rst_mid_no_done", 64'(any_done), 64'd0);
        check_eq("rst_mid_mem_untouched", 64'(dmem[0]), 64'h7777_7777);
        run_instr(2'b00, 4'd8, dc, en2, en3);
        check_eq("post_rst_done_cycle", 64'(dc), 64'd3);
        check_eq("post_rst_mem5", 64'(dmem[5]), 64'd105);

        // Single-lane instance: 4 steps, done in cycle 5
        preset(32'h0);
        start1 = 1'b1; op1 = 2'b00; vl1 = 3'd4;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) start1 = 1'b0;
            check_eq("l1_raddr", 64'(r_addr1[0]), 64'(c - 1));
            check_eq("l1_no_done", 64'(done1), 64'd0);
        end
        tick();
        check_eq("l1_done_c5", 64'(done1), 64'd1);
        check_eq("l1_wen_c5", 64'(w_en1), 64'd1);
        tick();
        check_eq("l1_ready_c6", 64'(ready1), 64'd1);
        check_eq("l1_mem3", 64'(dmem1[3]), 64'd16);
        check_eq("l1_mem0", 64'(dmem1[0]), 64'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
